change_dispenser: RTL

- Output-side companion to the coffee vending FSM: consumes its one-cycle `coffee` / `remain` vend result.
- Runs the physical dispense sequence: pours for a fixed time, then pays change as 50-unit coins to a coin hopper over a 4-phase req/ack handshake.
- Reports busy, completion, overrun and fault status back to the system.
- Sits between the vending FSM and the hopper/valve drivers.

---
 rtl/change_dispenser.sv | 115 +++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Dispense sequencer: pours for a fixed time, then pays change one 50-unit coin
// at a time over a 4-phase req/ack handshake with the coin hopper.
module change_dispenser #(
  parameter int POUR_CYCLES = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       coffee,
  input  logic [1:0] remain,
  input  logic       hopper_ack,
  output logic       coin_req,
  output logic       pour,
  output logic       busy,
  output logic       vend_done,
  output logic       overrun,
  output logic       fault,
  output logic [7:0] coins_paid
);

  localparam int TMAX = (POUR_CYCLES > ACK_TIMEOUT) ? POUR_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] POUR_LAST = TW'(POUR_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POUR, S_PAY_REQ, S_PAY_WAIT, S_DONE, S_FAULT
  } state_t;

  // Handshake: coin_req rises in PAY_REQ and stays high until hopper_ack=1 is
  // sampled; coin_req then drops and the next request waits for hopper_ack=0.
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pending_q, pending_d;
  logic [7:0]    coins_d;
  logic          overrun_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    coins_d   = coins_paid;
    overrun_d = overrun | (coffee && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (coffee) begin
          pending_d = remain;
          timer_d   = '0;
          state_d   = S_POUR;
        end
      end
      S_POUR: begin
        if (timer_q == POUR_LAST) begin
          timer_d = '0;
          state_d = (pending_q != 2'd0) ? S_PAY_REQ : S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PAY_REQ: begin
        if (hopper_ack) begin
          pending_d = pending_q - 2'd1;
          if (coins_paid != 8'hFF) coins_d = coins_paid + 8'd1;
          timer_d   = '0;
          state_d   = S_PAY_WAIT;
        end else if (timer_q == ACK_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PAY_WAIT: begin
        if (!hopper_ack) begin
          timer_d = '0;
          state_d = (pending_q != 2'd0) ? S_PAY_REQ : S_DONE;
        end else if (timer_q == ACK_LAST) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pending_q  <= 2'd0;
      coins_paid <= 8'd0;
      overrun    <= 1'b0;
      coin_req   <= 1'b0;
      pour       <= 1'b0;
      busy       <= 1'b0;
      vend_done  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      coins_paid <= coins_d;
      overrun    <= overrun_d;
      coin_req   <= (state_d == S_PAY_REQ);
      pour       <= (state_d == S_POUR);
      busy       <= (state_d != S_IDLE);
      vend_done  <= (state_d == S_DONE);
      fault      <= (state_d == S_FAULT);
    end
  end

endmodule
